// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with IR, BYPASS and IDCODE
// registers plus one-hot select for external data-register channels.
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH = 4,
    parameter int          NUM_DR   = 2,
    parameter logic [31:0] IDCODE   = 32'h0000_0001
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [NUM_DR-1:0]   dr_sel,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    input  logic [NUM_DR-1:0]   dr_tdo,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        RESET  = 4'hF, IDLE   = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_t;

    state_t              state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_q;
    logic [31:0]         idcode_q;
    logic                sel_idcode;
    logic                sel_ext;
    logic                sel_bypass;
    logic                dr_bit;

    always_ff @(posedge tck) begin
        if (trst) begin
            state <= RESET;
        end else begin
            case (state)
                RESET:   state <= tms ? RESET  : IDLE;
                IDLE:    state <= tms ? SEL_DR : IDLE;
                SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
                CAP_DR:  state <= tms ? EX1_DR : SH_DR;
                SH_DR:   state <= tms ? EX1_DR : SH_DR;
                EX1_DR:  state <= tms ? UPD_DR : PAU_DR;
                PAU_DR:  state <= tms ? EX2_DR : PAU_DR;
                EX2_DR:  state <= tms ? UPD_DR : SH_DR;
                UPD_DR:  state <= tms ? SEL_DR : IDLE;
                SEL_IR:  state <= tms ? RESET  : CAP_IR;
                CAP_IR:  state <= tms ? EX1_IR : SH_IR;
                SH_IR:   state <= tms ? EX1_IR : SH_IR;
                EX1_IR:  state <= tms ? UPD_IR : PAU_IR;
                PAU_IR:  state <= tms ? EX2_IR : PAU_IR;
                EX2_IR:  state <= tms ? UPD_IR : SH_IR;
                UPD_IR:  state <= tms ? SEL_DR : IDLE;
                default: state <= RESET;
            endcase
        end
    end

    always_comb begin
        dr_sel = '0;
        for (int i = 0; i < NUM_DR; i++) begin
            dr_sel[i] = (ir_value == IR_WIDTH'(i + 2));
        end
    end

    assign sel_idcode = (ir_value == IR_WIDTH'(1));
    assign sel_ext    = |dr_sel;
    assign sel_bypass = !sel_idcode && !sel_ext;

    always_comb begin
        dr_bit = bypass_q;
        unique case (1'b1)
            sel_idcode: dr_bit = idcode_q[0];
            sel_ext:    dr_bit = |(dr_tdo & dr_sel);
            default:    dr_bit = bypass_q;
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst || state == RESET) begin
            ir_sr    <= '0;
            ir_value <= IR_WIDTH'(1);
        end else begin
            case (state)
                CAP_IR:  ir_sr    <= IR_WIDTH'(2'b01);
                SH_IR:   ir_sr    <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR:  ir_value <= ir_sr;
                default: ;
            endcase
        end
    end

    // internal DRs only move while their own instruction is active
    always_ff @(posedge tck) begin
        if (trst) begin
            bypass_q <= 1'b0;
            idcode_q <= IDCODE;
        end else if (state == CAP_DR) begin
            if (sel_bypass) bypass_q <= 1'b0;
            if (sel_idcode) idcode_q <= IDCODE;
        end else if (state == SH_DR) begin
            if (sel_bypass) bypass_q <= tdi;
            if (sel_idcode) idcode_q <= {tdi, idcode_q[31:1]};
        end
    end

    always_ff @(negedge tck) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == SH_IR) || (state == SH_DR);
            if (state == SH_IR) begin
                tdo <= ir_sr[0];
            end else if (state == SH_DR) begin
                tdo <= dr_bit;
            end
        end
    end

    assign tap_state  = state;
    assign dr_capture = (state == CAP_DR) && sel_ext;
    assign dr_shift   = (state == SH_DR)  && sel_ext;
    assign dr_update  = (state == UPD_DR) && sel_ext;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed self-checking bench for jtag_tap_ctrl.
// Inputs change just after negedge; outputs are read after the negedge.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] ID = 32'h1234_5679;
    localparam logic [7:0]  PAT = 8'hA5;

    logic       tck = 1'b0;
    logic       trst = 1'b1;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic [1:0] dr_sel;
    logic       dr_capture;
    logic       dr_shift;
    logic       dr_update;
    logic [1:0] dr_tdo = 2'b00;
    logic [3:0] ir_value;
    logic [3:0] tap_state;

    int nvec = 0;
    int nerr = 0;
    int cap_n = 0;
    int sh_n = 0;
    int up_n = 0;
    int en_n = 0;
    logic [31:0] w;
    logic [7:0]  b;

    jtag_tap_ctrl #(
        .IR_WIDTH(4),
        .NUM_DR(2),
        .IDCODE(ID)
    ) dut (
        .tck(tck),
        .trst(trst),
        .tms(tms),
        .tdi(tdi),
        .tdo(tdo),
        .tdo_en(tdo_en),
        .dr_sel(dr_sel),
        .dr_capture(dr_capture),
        .dr_shift(dr_shift),
        .dr_update(dr_update),
        .dr_tdo(dr_tdo),
        .ir_value(ir_value),
        .tap_state(tap_state)
    );

    always #5 tck = ~tck;

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
        cap_n += int'(dr_capture);
        sh_n  += int'(dr_shift);
        up_n  += int'(dr_update);
        en_n  += int'(tdo_en);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ir_load(input logic [3:0] v);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int k = 0; k < 4; k++) tick(k == 3, v[k]);
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        tick(1, 0);
        tick(1, 0);
        chk("rst_state", tap_state, 4'hF);
        chk("rst_ir", ir_value, 4'h1);
        chk("rst_sel", dr_sel, 2'b00);
        chk("rst_enables", {dr_capture, dr_shift, dr_update}, 3'b000);
        chk("rst_tdo", {tdo, tdo_en}, 2'b00);
        trst = 1'b0;

        // IDCODE read
        tick(0, 0);
        chk("idle", tap_state, 4'hC);
        tick(1, 0);
        tick(0, 0);
        chk("capdr", tap_state, 4'h6);
        en_n = 0;
        tick(0, 0);
        chk("shdr", tap_state, 4'h2);
        for (int k = 0; k < 32; k++) begin
            w[k] = tdo;
            tick(k == 31, 0);
        end
        chk("id_word", w, ID);
        chk("id_en_cnt", en_n, 32);
        chk("id_en_off", tdo_en, 1'b0);
        chk("ex1dr", tap_state, 4'h1);
        tick(1, 0);
        tick(0, 0);
        chk("id_ir", ir_value, 4'h1);

        // TMS reset from ShDR
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int k = 0; k < 4; k++) tick(1, 0);
        chk("tms4_shdr", tap_state, 4'h4);
        tick(1, 0);
        chk("tms5_shdr", tap_state, 4'hF);
        chk("tms5_ir", ir_value, 4'h1);

        // TMS reset from PauIR
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        chk("pauir", tap_state, 4'hB);
        for (int k = 0; k < 4; k++) tick(1, 0);
        chk("tms4_pauir", tap_state, 4'h4);
        tick(1, 0);
        chk("tms5_pauir", tap_state, 4'hF);
        chk("tms5p_ir", ir_value, 4'h1);

        // IR capture then BYPASS
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        chk("shir", tap_state, 4'hA);
        chk("ir_cap_b0", tdo, 1'b1);
        tick(0, 1);
        chk("ir_cap_b1", tdo, 1'b0);
        tick(0, 1);
        tick(0, 1);
        tick(1, 1);
        chk("ex1ir", tap_state, 4'h9);
        tick(1, 0);
        tick(0, 0);
        chk("ir_ones", ir_value, 4'hF);
        chk("byp_sel", dr_sel, 2'b00);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        chk("byp_b0", tdo, 1'b0);
        tick(0, 1);
        chk("byp_b1", tdo, 1'b1);
        tick(0, 0);
        chk("byp_b2", tdo, 1'b0);
        tick(0, 1);
        chk("byp_b3", tdo, 1'b1);
        tick(1, 1);
        tick(1, 0);
        tick(0, 0);

        // external channel 1
        ir_load(4'h3);
        chk("ext_ir", ir_value, 4'h3);
        chk("ext_sel", dr_sel, 2'b10);
        cap_n = 0;
        sh_n = 0;
        up_n = 0;
        tick(1, 0);
        tick(0, 0);
        for (int k = 0; k < 8; k++) begin
            dr_tdo = {PAT[k], ~PAT[k]};
            tick(0, 0);
            b[k] = tdo;
        end
        dr_tdo = 2'b00;
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        chk("ext_tdo", b, PAT);
        chk("ext_cap_cnt", cap_n, 1);
        chk("ext_sh_cnt", sh_n, 8);
        chk("ext_up_cnt", up_n, 1);

        // IDCODE with pause/resume
        for (int k = 0; k < 5; k++) tick(1, 0);
        chk("pr_ir", ir_value, 4'h1);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int k = 0; k < 10; k++) begin
            w[k] = tdo;
            tick(k == 9, 0);
        end
        for (int k = 0; k < 5; k++) tick(0, 0);
        chk("paudr", tap_state, 4'h3);
        tick(1, 0);
        tick(0, 0);
        for (int k = 10; k < 32; k++) begin
            w[k] = tdo;
            tick(k == 31, 0);
        end
        tick(1, 0);
        tick(0, 0);
        chk("pr_word", w, ID);

        // trst in the middle of an external shift
        ir_load(4'h2);
        chk("mt_sel", dr_sel, 2'b01);
        up_n = 0;
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        chk("mt_shift", dr_shift, 1'b1);
        trst = 1'b1;
        tick(0, 0);
        chk("mt_state", tap_state, 4'hF);
        chk("mt_en", tdo_en, 1'b0);
        chk("mt_ir", ir_value, 4'h1);
        chk("mt_sel0", dr_sel, 2'b00);
        trst = 1'b0;
        tick(1, 0);
        tick(1, 0);
        chk("mt_up_cnt", up_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

Parametrised JTAG TAP controller. Combines the IEEE 1149.1 16-state TAP FSM with an integrated instruction register, a BYPASS register, an IDCODE register, and a one-hot select for `NUM_DR` external data-register channels. All storage updates on the rising edge of `tck` using single-cycle enables; there are no gated clocks. `tdo` is retimed on the falling edge. It sits between the chip-level JTAG pins and the user scan chains, such as boundary scan and debug registers.

## Interface
- `IR_WIDTH`, default 4: instruction register width. Must be ≥ 2 and satisfy 2^IR_WIDTH > NUM_DR + 2.
- `NUM_DR`, default 2: number of external DR channels. Must be ≥ 1.
- `IDCODE`, default 32'h0000_0001: IDCODE capture value. bit0 must be 1.
- `tck`  in  1: the block's only clock. All state updates on posedge; the `tdo`/`tdo_en` flops update on negedge.
- `trst`  in  1: synchronous reset, active-high. Sampled on the clock edge of each flop.
- `tms`  in  1: test mode select.
- `tdi`  in  1: test data in.
- `tdo`  out  1: test data out.
- `tdo_en`  out  1: output enable for `tdo`.
- `dr_sel`  out  NUM_DR: one-hot external channel select. All zero when no external channel is selected.
- `dr_capture`  out  1: capture enable for the selected channel.
- `dr_shift`  out  1: shift enable for the selected channel.
- `dr_update`  out  1: update enable for the selected channel.
- `dr_tdo`  in  NUM_DR: serial outputs of the external channels.
- `ir_value`  out  IR_WIDTH: current active instruction.
- `tap_state`  out  4: current FSM state, for debug.

## Operation
- **FSM states and 4-bit encoding:**
  - Reset F, Idle C.
  - DR path: SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5.
  - IR path: SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
  - Transitions follow IEEE 1149.1 exactly. Unused encodings go to Reset.
  - Five consecutive tms=1 cycles reach Reset from any state.
- **Instruction decode** (from `ir_value`):
  - 1 selects IDCODE.
  - i+2 (for 0 ≤ i < NUM_DR) selects external channel i.
  - Every other value, including all-ones and 0, selects BYPASS.
- **IR shift register** (`ir_sr`), on posedge:
  - In CapIR: loads {0…0, 2'b01}.
  - In ShIR: `ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}`, LSB first out.
  - In UpdIR: `ir_value <= ir_sr`.
- **Reset state**, entered via Reset state or `trst`: `ir_value` = 1 (IDCODE) and `ir_sr` = 0.
- **BYPASS** (1 bit): cleared to 0 in CapDR; loads `tdi` in ShDR.
- **IDCODE** (32 bits): loads `IDCODE` in CapDR; in ShDR shifts right with `tdi` entering bit31.
- **Internal registers** only capture or shift when their instruction is active.
- **External channel handshake:**
  - `dr_sel` is a pure decode of `ir_value`.
  - `dr_capture` = (state==CapDR) & |dr_sel.
  - `dr_shift` = (state==ShDR) & |dr_sel.
  - `dr_update` = (state==UpdDR) & |dr_sel.
  - The channel acts on the posedge where the enable is high. The enable is high for exactly one cycle per visit to CapDR or UpdDR.
- **tdo path**, on negedge:
  - In ShIR: `tdo <= ir_sr[0]`.
  - In ShDR: `tdo <=` bit0 of the selected DR. For external channels that is `dr_tdo[i]`.
  - Otherwise `tdo` holds its value.
  - `tdo_en <=` (state ∈ {ShIR, ShDR}).
- **Pause/Exit states:** no register changes. A shift resumes without loss via Ex2→Sh.

## Timing
- **Reset values:**
  - `tap_state` = F.
  - `ir_value` = 1 (IDCODE), so `dr_sel` = 0.
  - `dr_capture`, `dr_shift`, `dr_update` = 0.
  - `tdo` = 0 and `tdo_en` = 0 (the negedge flops take reset on the first negedge with `trst` high).
- **`trst` mid-shift:** on the next posedge the FSM is in Reset and `ir_value` is IDCODE. The partially shifted data in `ir_sr` and the DRs is discarded. External channels see no update strobe.
- **Latency:**
  - The state changes one posedge after `tms` is sampled.
  - The first `tdo` bit of a shift appears at the negedge following the posedge that entered ShDR/ShIR.
  - The n-th bit appears n−1 cycles later.
- **Instruction switch:** the new `ir_value` and `dr_sel` are valid from the posedge that leaves UpdIR. Old-channel enables never overlap new-channel enables.
- **Stability:** all outputs except `tdo`/`tdo_en` are decodes of posedge registers and are stable across the whole cycle.

## Test plan
- **Reset and IDCODE read:** `trst` high for 2 cycles, then tms 0,1,0,0 followed by 32 ShDR cycles. Required: `tdo` sequence equals `IDCODE` LSB first, `tdo_en` high only during the shift, and `ir_value` = 1.
- **TMS reset:** from ShDR (and from PauIR), apply tms=1 for five cycles. Required: `tap_state` = F after exactly the fifth posedge, `ir_value` = 1.
- **IR capture and BYPASS:** shift `IR_WIDTH` ones into the IR. Required: first two `tdo` bits are 1 then 0. After UpdIR, `ir_value` is all-ones, and a DR shift of tdi pattern 1011 returns `tdo` 0,1,0,1 (one-bit delay behind the captured 0).
- **External channel 1:** load IR = 3. Required: `dr_sel` = 2'b10. One DR scan of 8 bits gives `dr_capture` high for 1 cycle, `dr_shift` high for 8 cycles, and `dr_update` high for 1 cycle. `tdo` mirrors the `dr_tdo[1]` stimulus one negedge later.
- **Pause/resume:** an IDCODE shift of 10 bits, then PauDR for 5 cycles, then Ex2→ShDR for 22 bits. Required: the concatenated `tdo` equals `IDCODE`, with no repeated or lost bit.
- **Mid-shift trst:** assert `trst` during bit 3 of an external DR shift. Required: `dr_update` never asserts, state is F, and `tdo_en` = 0 at the next negedge.
